cl_symbol_histogram: RTL
========================

// Module: cl_symbol_histogram
// PURPOSE
//  Downstream of clcoding. Counts occurrences of the 19 DEFLATE code-length (CL)
//  alphabet symbols (0-15 literal lengths, 16/17/18 run codes) in one block.
//  At block end, streams the 19 frequencies in symbol order to the CL Huffman
//  tree builder, then clears and rearms for the next block.
// PARAMETERS
//  NUM_SYM  19  CL alphabet size; fixed by DEFLATE, not for override
//  SYM_W    5   width of input symbol field
//  CNT_W    9   frequency counter width (>= 316 = 286 lit/len + 30 dist)
// PORTS
//  clk              in   1      single clock, all logic on posedge
//  reset            in   1      synchronous, active-low
//  in_valid         in   1      CL symbol beat valid
//  in_ready         out  1      block can accept a beat
//  in_sym           in   SYM_W  CL symbol, legal range 0..18
//  in_last          in   1      final symbol of block (qualified by in_valid)
//  out_valid        out  1      frequency entry valid
//  out_ready        in   1      downstream accepts entry
//  out_sym          out  SYM_W  symbol index of entry, 0..18
//  out_freq         out  CNT_W  count for out_sym
//  out_last         out  1      high with entry 18
//  out_nz_cnt       out  5      number of symbols with freq != 0; valid with out_last
//  err_sym          out  1      sticky: an in_sym >= 19 was accepted
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=ACCUM, freq[0..18]=0, idx=0, nz=0,
//   err_sym=0. While reset is low, in_ready=0 and out_valid=0.
//  States: ACCUM, FLUSH.
//  - ACCUM: in_ready=1, out_valid=0. Beat accepted when in_valid&in_ready.
//    - in_sym<19: freq[in_sym]+=1, saturating at 2^CNT_W-1 (no wrap).
//      If freq[in_sym] was 0, nz+=1.
//    - in_sym>=19: no count, err_sym<=1.
//    - Accepted with in_last=1: that beat is counted, then state<=FLUSH, idx<=0.
//  - FLUSH: in_ready=0. out_valid=1; out_sym=idx; out_freq=freq[idx];
//    out_last=(idx==18); out_nz_cnt=nz (value meaningful only when out_last=1).
//    - Outputs hold stable while out_ready=0.
//    - On out_valid&out_ready: idx+=1.
//    - On the idx==18 handshake: all freq<=0, nz<=0, idx<=0, state<=ACCUM.
//      err_sym is not cleared; it clears only on reset.
//  Latency: first entry valid the cycle after the in_last accept. With
//   out_ready held high, a flush takes exactly 19 cycles. in_ready returns
//   the cycle after the final handshake.
//  in_valid while in FLUSH: ignored. Upstream must hold the beat (valid/ready).
//  in_last on an illegal symbol: not counted, flush still starts.
//  All outputs are combinational from registered state/counters. There is no
//   combinational path from in_* or out_ready to any output.
//  Reset mid-FLUSH or mid-ACCUM: all counts are discarded and the block
//   returns to reset values.
// TESTING
//  1. Reset, then syms 0,0,18,5 with last on 5 -> 19 entries; freq0=2,
//     freq5=1, freq18=1, all others 0; out_nz_cnt=3.
//  2. Single beat sym 7 with in_last -> out_valid the next cycle.
//     Entries 0..18 with freq7=1, out_nz_cnt=1, and in_ready=0 throughout.
//  3. 600 beats of sym 16, then last -> freq16=511 (saturated), no wrap.
//  4. Backpressure: toggle out_ready randomly during flush -> each entry seen
//     exactly once, in order, with stable fields while stalled.
//  5. Illegal sym 25 mid-block -> err_sym=1, counts unaffected. A second block
//     starts from zero counts and err_sym stays 1.
//  6. Drive reset low at flush entry 9 -> no further out_valid. Next block
//     counts start from 0.

Source files
------------

// File: rtl/cl_symbol_histogram_if.sv
// Stream bundle for the CL symbol histogram: symbol input beats, frequency
// output entries and the sticky illegal-symbol flag.
interface cl_symbol_histogram_if #(
  parameter int SYM_W = 5,
  parameter int CNT_W = 9
);
  logic             in_valid;
  logic             in_ready;
  logic [SYM_W-1:0] in_sym;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [SYM_W-1:0] out_sym;
  logic [CNT_W-1:0] out_freq;
  logic             out_last;
  logic [4:0]       out_nz_cnt;
  logic             err_sym;

  modport master (
    output in_valid, in_sym, in_last, out_ready,
    input  in_ready, out_valid, out_sym, out_freq, out_last, out_nz_cnt, err_sym
  );

  modport slave (
    input  in_valid, in_sym, in_last, out_ready,
    output in_ready, out_valid, out_sym, out_freq, out_last, out_nz_cnt, err_sym
  );
endinterface

// File: rtl/cl_symbol_histogram.sv
// Counts DEFLATE code-length symbols over one block, then streams the 19
// saturating frequencies in symbol order and rearms for the next block.
module cl_symbol_histogram #(
  parameter int NUM_SYM = 19,
  parameter int SYM_W   = 5,
  parameter int CNT_W   = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  cl_symbol_histogram_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [SYM_W-1:0] LAST_IDX = SYM_W'(NUM_SYM - 1);
  localparam logic [SYM_W-1:0] SYM_LIM  = SYM_W'(NUM_SYM);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_freq [NUM_SYM];
  logic [SYM_W-1:0] r_idx;
  logic [4:0]       r_nz;
  logic             r_err_sym;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_sym_legal;
  logic             w_flush_done;
  logic             w_hit_zero;
  logic [CNT_W-1:0] w_out_freq;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, handshake enables and flush completion; outputs drop while reset is held low
  always_comb begin
    w_state_nxt  = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    w_in_fire    = 1'b0;
    w_out_fire   = 1'b0;
    w_flush_done = 1'b0;
    w_sym_legal  = (bus.in_sym < SYM_LIM);
    case (r_state)
      ST_ACCUM: begin
        w_in_ready = reset;
        w_in_fire  = bus.in_valid & w_in_ready;
        if (w_in_fire && bus.in_last) begin
          w_state_nxt = ST_FLUSH;
        end else begin
          w_state_nxt = ST_ACCUM;
        end
      end
      ST_FLUSH: begin
        w_out_valid  = reset;
        w_out_fire   = w_out_valid & bus.out_ready;
        w_flush_done = w_out_fire & (r_idx == LAST_IDX);
        if (w_flush_done) begin
          w_state_nxt = ST_ACCUM;
        end else begin
          w_state_nxt = ST_FLUSH;
        end
      end
      default: begin
        w_state_nxt = ST_ACCUM;
      end
    endcase
  end

  // Decode the incoming symbol's bin and the bin being flushed
  always_comb begin
    w_hit_zero = 1'b0;
    w_out_freq = {CNT_W{1'b0}};
    for (int i = 0; i < NUM_SYM; i++) begin
      if (bus.in_sym == SYM_W'(i)) begin
        w_hit_zero = (r_freq[i] == {CNT_W{1'b0}});
      end else begin
        w_hit_zero = w_hit_zero;
      end
      if (r_idx == SYM_W'(i)) begin
        w_out_freq = r_freq[i];
      end else begin
        w_out_freq = w_out_freq;
      end
    end
  end

  // Frequency bins, flush index and nonzero count; err_sym survives block clears
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SYM; i++) begin
        r_freq[i] <= {CNT_W{1'b0}};
      end
      r_idx     <= {SYM_W{1'b0}};
      r_nz      <= 5'd0;
      r_err_sym <= 1'b0;
    end else if (w_flush_done) begin
      for (int i = 0; i < NUM_SYM; i++) begin
        r_freq[i] <= {CNT_W{1'b0}};
      end
      r_idx <= {SYM_W{1'b0}};
      r_nz  <= 5'd0;
    end else begin
      if (w_out_fire) begin
        r_idx <= r_idx + SYM_W'(1);
      end else if (w_in_fire && bus.in_last) begin
        r_idx <= {SYM_W{1'b0}};
      end
      for (int i = 0; i < NUM_SYM; i++) begin
        if (w_in_fire && (bus.in_sym == SYM_W'(i)) && (r_freq[i] != CNT_MAX)) begin
          r_freq[i] <= r_freq[i] + CNT_W'(1);
        end
      end
      if (w_in_fire && w_sym_legal && w_hit_zero) begin
        r_nz <= r_nz + 5'd1;
      end
      if (w_in_fire && !w_sym_legal) begin
        r_err_sym <= 1'b1;
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_sym    = r_idx;
  assign bus.out_freq   = w_out_freq;
  assign bus.out_last   = w_out_valid & (r_idx == LAST_IDX);
  assign bus.out_nz_cnt = r_nz;
  assign bus.err_sym    = r_err_sym;

endmodule
